// File: rtl/countdown_timer_if.sv
// countdown_timer_if: timer control/status bundle; master drives load/load_min/load_sec/start/stop/clear and reads minutes/seconds/status/expired/alarm, slave is the timer
interface countdown_timer_if;
  logic       load;
  logic [7:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic       expired;
  logic       alarm;
  modport master (
    output load, load_min, load_sec, start, stop, clear,
    input  minutes, seconds, status, expired, alarm
  );
  modport slave (
    input  load, load_min, load_sec, start, stop, clear,
    output minutes, seconds, status, expired, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable mm:ss countdown with alarm; clk, rst_n (sync active-low), bus.slave carries commands in and time/status/expired/alarm out
module countdown_timer #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10, EXPIRED = 2'b11} state_t;
  state_t        st_q, st_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          exp_q, exp_d;
  logic          tick, zero;
  assign tick = ps_q == PW'(TICKS_PER_SEC - 1);
  assign zero = min_q == 8'd0 && sec_q == 6'd0;
  always_comb begin
    st_d  = st_q;
    min_d = min_q;
    sec_d = sec_q;
    ps_d  = ps_q;
    exp_d = 1'b0;
    if (bus.clear) begin
      st_d  = IDLE;
      min_d = '0;
      sec_d = '0;
      ps_d  = '0;
    end else if (bus.load && st_q != RUN) begin
      st_d  = IDLE;
      min_d = bus.load_min;
      sec_d = bus.load_sec > 6'd59 ? 6'd59 : bus.load_sec;
      ps_d  = '0;
    end else if (st_q == RUN) begin
      // the stop edge still counts as a running edge, so a paused partial second resumes where it left off
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        min_d = sec_q == 6'd0 ? min_q - 1'b1 : min_q;
        sec_d = sec_q == 6'd0 ? 6'd59 : sec_q - 1'b1;
      end
      if (tick && min_q == 8'd0 && sec_q == 6'd1) begin
        st_d  = EXPIRED;
        exp_d = 1'b1;
      end else if (bus.stop)
        st_d = PAUSED;
    end else if (bus.start && !bus.stop && st_q != EXPIRED && !zero)
      st_d = RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      min_q <= '0;
      sec_q <= '0;
      ps_q  <= '0;
      exp_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      min_q <= min_d;
      sec_q <= sec_d;
      ps_q  <= ps_d;
      exp_q <= exp_d;
    end
  end
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.status  = st_q;
  assign bus.expired = exp_q;
  assign bus.alarm   = st_q == EXPIRED;
endmodule
